// File: rtl/hwpe_tcdm_rr_arbiter.sv
// hwpe_tcdm_rr_arbiter
// Shares one TCDM master port between N_REQ streamer requesters with
// round-robin priority. Accepted transactions record their issuer in an
// ordered ID FIFO so that in-order responses can be steered back to it.
module hwpe_tcdm_rr_arbiter #(
  parameter int N_REQ           = 3,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              in_req,
  output logic [N_REQ-1:0]              in_gnt,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   in_add,
  input  logic [N_REQ-1:0]              in_wen,
  input  logic [N_REQ*DATA_WIDTH/8-1:0] in_be,
  input  logic [N_REQ*DATA_WIDTH-1:0]   in_data,
  output logic [DATA_WIDTH-1:0]         in_r_data,
  output logic [N_REQ-1:0]              in_r_valid,
  output logic                          out_req,
  input  logic                          out_gnt,
  output logic [ADDR_WIDTH-1:0]         out_add,
  output logic                          out_wen,
  output logic [DATA_WIDTH/8-1:0]       out_be,
  output logic [DATA_WIDTH-1:0]         out_data,
  input  logic [DATA_WIDTH-1:0]         out_r_data,
  input  logic                          out_r_valid,
  output logic                          busy,
  output logic                          err
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int IW   = $clog2(N_REQ);
  localparam int PW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW   = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [IW-1:0] LAST_IDX  = IW'(N_REQ - 1);
  localparam logic [IW:0]   N_REQ_W   = (IW+1)'(N_REQ);
  localparam logic [PW-1:0] LAST_SLOT = PW'(MAX_OUTSTANDING - 1);
  localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_OUTSTANDING);

  logic [IW-1:0] ptr;
  logic          lock;
  logic [IW-1:0] lock_idx;
  logic [IW-1:0] fifo [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          err_q;

  logic [IW-1:0] rr_sel;
  logic          rr_hit;
  logic [IW:0]   cand_sum;
  logic [IW-1:0] cand;
  logic [IW-1:0] sel;
  logic          full;
  logic          req_int;
  logic          push;
  logic          pop;

  // Round-robin search: first requester at or after ptr, wrapping modulo N_REQ
  always_comb begin
    rr_sel   = ptr;
    rr_hit   = 1'b0;
    cand_sum = '0;
    cand     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_sum = {1'b0, ptr} + (IW+1)'(k);
      if (cand_sum >= N_REQ_W) cand_sum = cand_sum - N_REQ_W;
      cand = cand_sum[IW-1:0];
      if (!rr_hit && in_req[cand]) begin
        rr_sel = cand;
        rr_hit = 1'b1;
      end
    end
  end

  // Selection and handshake qualifiers; full comes only from registered count
  always_comb begin
    full    = (count == MAX_CNT);
    sel     = lock ? lock_idx : rr_sel;
    req_int = !rst && !full && (lock || (|in_req));
    push    = req_int && out_gnt;
    pop     = !rst && out_r_valid && (count != '0);
  end

  // Output muxing and response steering; everything is held at 0 during reset
  always_comb begin
    out_req    = req_int;
    out_add    = '0;
    out_wen    = 1'b0;
    out_be     = '0;
    out_data   = '0;
    in_r_data  = '0;
    in_gnt     = '0;
    in_r_valid = '0;
    if (!rst) begin
      out_add   = in_add[sel*ADDR_WIDTH +: ADDR_WIDTH];
      out_wen   = in_wen[sel];
      out_be    = in_be[sel*BE_W +: BE_W];
      out_data  = in_data[sel*DATA_WIDTH +: DATA_WIDTH];
      in_r_data = out_r_data;
    end
    if (push) in_gnt[sel] = 1'b1;
    if (pop) in_r_valid[fifo[rd_ptr]] = 1'b1;
    busy = !rst && ((count != '0) || req_int);
    err  = !rst && err_q;
  end

  // Control state: priority pointer, lock, FIFO pointers, occupancy, sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (req_int && !out_gnt) begin
        lock     <= 1'b1;
        lock_idx <= sel;
      end else if (push) begin
        lock   <= 1'b0;
        ptr    <= (sel == LAST_IDX) ? '0 : sel + 1'b1;
        wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (out_r_valid && (count == '0)) err_q <= 1'b1;
    end
  end

  // ID FIFO storage: issuer index of each accepted transaction, oldest at rd_ptr
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= sel;
  end

endmodule

// File: tb/tb_hwpe_tcdm_rr_arbiter.sv
// Testbench for hwpe_tcdm_rr_arbiter: directed scenarios and random traffic,
// checked each cycle against a queue-based behavioural model.
module tb_hwpe_tcdm_rr_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MO = 4;
  localparam int BW = DW / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      in_req;
  logic [N-1:0]      in_gnt;
  logic [N*AW-1:0]   in_add;
  logic [N-1:0]      in_wen;
  logic [N*BW-1:0]   in_be;
  logic [N*DW-1:0]   in_data;
  logic [DW-1:0]     in_r_data;
  logic [N-1:0]      in_r_valid;
  logic              out_req;
  logic              out_gnt;
  logic [AW-1:0]     out_add;
  logic              out_wen;
  logic [BW-1:0]     out_be;
  logic [DW-1:0]     out_data;
  logic [DW-1:0]     out_r_data;
  logic              out_r_valid;
  logic              busy;
  logic              err;

  always #5 clk = ~clk;

  hwpe_tcdm_rr_arbiter #(
    .N_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst(rst),
    .in_req(in_req), .in_gnt(in_gnt), .in_add(in_add), .in_wen(in_wen),
    .in_be(in_be), .in_data(in_data), .in_r_data(in_r_data), .in_r_valid(in_r_valid),
    .out_req(out_req), .out_gnt(out_gnt), .out_add(out_add), .out_wen(out_wen),
    .out_be(out_be), .out_data(out_data), .out_r_data(out_r_data),
    .out_r_valid(out_r_valid), .busy(busy), .err(err)
  );

  int vectors = 0;
  int miscompares = 0;

  // stimulus state
  bit            s_rst;
  bit            s_gnt;
  bit            s_rv;
  logic [DW-1:0] s_rdata;
  bit            s_req  [N];
  logic [AW-1:0] s_add  [N];
  bit            s_wen  [N];
  logic [BW-1:0] s_be   [N];
  logic [DW-1:0] s_data [N];
  bit            auto_drop;

  // reference model
  int m_ptr;
  bit m_lock;
  int m_lock_idx;
  int q[$];
  bit m_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic new_fields(input int i);
    s_add[i]  = $urandom;
    s_wen[i]  = ($urandom_range(0, 1) == 1);
    s_be[i]   = BW'($urandom);
    s_data[i] = $urandom;
  endtask

  // One clock: drive at negedge, check at negedge+1, then advance the model
  task automatic step();
    int sel;
    bit full, oreq, hs, pop;
    logic [N-1:0] eg, erv;
    @(negedge clk);
    rst         = s_rst;
    out_gnt     = s_gnt;
    out_r_valid = s_rv;
    out_r_data  = s_rdata;
    for (int i = 0; i < N; i++) begin
      in_req[i]           = s_req[i];
      in_add[i*AW +: AW]  = s_add[i];
      in_wen[i]           = s_wen[i];
      in_be[i*BW +: BW]   = s_be[i];
      in_data[i*DW +: DW] = s_data[i];
    end
    #1;
    if (s_rst) begin
      check("rst_out_req", 64'(out_req), 64'(0));
      check("rst_in_gnt", 64'(in_gnt), 64'(0));
      check("rst_in_r_valid", 64'(in_r_valid), 64'(0));
      check("rst_in_r_data", 64'(in_r_data), 64'(0));
      check("rst_out_add", 64'(out_add), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_err", 64'(err), 64'(0));
      m_ptr = 0;
      m_lock = 1'b0;
      m_lock_idx = 0;
      q.delete();
      m_err = 1'b0;
    end else begin
      full = (q.size() == MO);
      sel = -1;
      if (m_lock) sel = m_lock_idx;
      else
        for (int k = 0; k < N; k++)
          if (sel < 0 && s_req[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
      oreq = (sel >= 0) && !full;
      hs   = oreq && s_gnt;
      pop  = s_rv && (q.size() > 0);
      eg = '0;
      if (hs) eg[sel] = 1'b1;
      erv = '0;
      if (pop) erv[q[0]] = 1'b1;
      check("out_req", 64'(out_req), 64'(oreq));
      check("in_gnt", 64'(in_gnt), 64'(eg));
      check("in_r_valid", 64'(in_r_valid), 64'(erv));
      check("in_r_data", 64'(in_r_data), 64'(s_rdata));
      check("busy", 64'(busy), 64'((q.size() != 0) || oreq));
      check("err", 64'(err), 64'(m_err));
      if (oreq) begin
        check("out_add", 64'(out_add), 64'(s_add[sel]));
        check("out_wen", 64'(out_wen), 64'(s_wen[sel]));
        check("out_be", 64'(out_be), 64'(s_be[sel]));
        check("out_data", 64'(out_data), 64'(s_data[sel]));
      end
      if (s_rv && q.size() == 0) m_err = 1'b1;
      if (pop) void'(q.pop_front());
      if (oreq && !s_gnt) begin
        m_lock = 1'b1;
        m_lock_idx = sel;
      end
      if (hs) begin
        m_lock = 1'b0;
        m_ptr = (sel + 1) % N;
        q.push_back(sel);
        if (auto_drop) s_req[sel] = ($urandom_range(0, 1) == 1);
        new_fields(sel);
      end
    end
    s_rdata = $urandom;
  endtask

  task automatic set_req(input logic [N-1:0] r);
    for (int i = 0; i < N; i++) s_req[i] = r[i];
  endtask

  // Empty the model queue and release any lock, bounded
  task automatic drain();
    int n = 0;
    s_gnt = 1'b1;
    while ((q.size() > 0 || m_lock) && n < 20) begin
      if (!m_lock) set_req('0);
      s_rv = (q.size() > 0);
      step();
      n++;
    end
    check("drain_done", 64'(q.size() == 0 && !m_lock), 64'(1));
    set_req('0);
    s_rv = 1'b0;
  endtask

  logic [N-1:0] exp_g;

  initial begin
    rst = 1'b1;
    s_rst = 1'b1;
    s_gnt = 1'b0;
    s_rv = 1'b0;
    s_rdata = '0;
    auto_drop = 1'b0;
    for (int i = 0; i < N; i++) begin
      s_req[i] = 1'b0;
      new_fields(i);
    end
    m_ptr = 0; m_lock = 1'b0; m_lock_idx = 0; m_err = 1'b0;

    // reset
    step();
    step();
    s_rst = 1'b0;

    // locked selection: idx0 held while out_gnt low, then idx2 next
    set_req(3'b101);
    s_gnt = 1'b0;
    repeat (3) begin
      step();
      check("t2_locked_add", 64'(out_add), 64'(s_add[0]));
    end
    s_gnt = 1'b1;
    step();
    check("t2_gnt0", 64'(in_gnt), 64'(3'b001));
    step();
    check("t2_gnt2", 64'(in_gnt), 64'(3'b100));
    drain();

    // all requesting, grant every cycle: 0,1,2,0,...
    set_req(3'b111);
    s_gnt = 1'b1;
    for (int k = 0; k < 9; k++) begin
      s_rv = (q.size() > 0);
      step();
      exp_g = 3'b001 << (k % 3);
      check("t1_order", 64'(in_gnt), 64'(exp_g));
    end
    drain();

    // fill to MAX_OUTSTANDING, then one response reopens the port
    set_req(3'b111);
    s_gnt = 1'b1;
    s_rv = 1'b0;
    repeat (5) step();
    check("t3_full_req", 64'(out_req), 64'(0));
    check("t3_full_busy", 64'(busy), 64'(1));
    s_rv = 1'b1;
    step();
    check("t3_pop_req", 64'(out_req), 64'(0));
    s_rv = 1'b0;
    step();
    check("t3_reopen", 64'(out_req), 64'(1));
    drain();

    // simultaneous push and pop at count 2
    set_req(3'b111);
    s_gnt = 1'b1;
    s_rv = 1'b0;
    repeat (2) step();
    s_rv = 1'b1;
    repeat (4) step();
    drain();

    // random traffic
    auto_drop = 1'b1;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++)
        if (!s_req[i] && $urandom_range(0, 3) == 0) begin
          s_req[i] = 1'b1;
          new_fields(i);
        end
      s_gnt = ($urandom_range(0, 3) != 0);
      s_rv  = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      step();
    end
    auto_drop = 1'b0;
    drain();

    // stray response with nothing outstanding
    s_rv = 1'b1;
    step();
    check("t5_no_route", 64'(in_r_valid), 64'(0));
    s_rv = 1'b0;
    repeat (3) step();
    check("t5_err_sticky", 64'(err), 64'(1));

    // reset in the middle of traffic with count 3 and a lock
    s_rst = 1'b1;
    step();
    s_rst = 1'b0;
    check("t5_err_cleared_model", 64'(m_err), 64'(0));
    step();
    check("t5_err_cleared", 64'(err), 64'(0));
    set_req(3'b111);
    s_gnt = 1'b1;
    repeat (3) step();
    s_gnt = 1'b0;
    step();
    s_rst = 1'b1;
    step();
    s_rst = 1'b0;
    set_req(3'b000);
    s_gnt = 1'b1;
    step();
    check("t6_idle_busy", 64'(busy), 64'(0));
    set_req(3'b010);
    step();
    check("t6_first_gnt", 64'(in_gnt), 64'(3'b010));
    set_req(3'b000);
    s_rv = 1'b1;
    step();
    check("t6_route", 64'(in_r_valid), 64'(3'b010));
    s_rv = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
